// File: rtl/glitch_pulse_seq.sv
// glitch_pulse_seq
// ----------------
// Glitch pulse sequencer. After the host arms it, the block waits for a
// qualified edge on the synchronised target trigger. It then emits a train
// of pulses, set by a delay, a pulse width, a pulse count and a spacing.
//
// Parameters
//   DELAY_W     width of delay counter / delay_i
//   WIDTH_W     width of pulse-width counter / width_i
//   COUNT_W     width of pulse counter / num_pulses_i
//   SPACING_W   width of spacing counter / spacing_i
//   SYNC_STAGES trigger synchroniser depth (>= 2)
//
// Ports
//   clk            single clock
//   rst            synchronous active-low reset
//   trigger_i      asynchronous target trigger
//   arm_i          one-cycle strobe: arm and latch configuration (IDLE only)
//   abort_i        level: return to IDLE from any other state
//   delay_i        cycles from qualified edge to first pulse
//   width_i        pulse high time (0 behaves as 1)
//   num_pulses_i   pulses per train (0 makes the arm a no-op)
//   spacing_i      low time between pulses (0 behaves as 1)
//   trig_falling_i 0 = rising edge, 1 = falling edge
//   auto_rearm_i   after a train go back to ARMED instead of IDLE
//   pulse_o        registered glitch pulse
//   armed_o        high in ARMED
//   busy_o         high in DELAY, PULSE or SPACE
//   done_o         one-cycle strobe at the end of a train
module glitch_pulse_seq #(
  parameter int DELAY_W     = 16,
  parameter int WIDTH_W     = 8,
  parameter int COUNT_W     = 8,
  parameter int SPACING_W   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger_i,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic [DELAY_W-1:0]   delay_i,
  input  logic [WIDTH_W-1:0]   width_i,
  input  logic [COUNT_W-1:0]   num_pulses_i,
  input  logic [SPACING_W-1:0] spacing_i,
  input  logic                 trig_falling_i,
  input  logic                 auto_rearm_i,
  output logic                 pulse_o,
  output logic                 armed_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    PULSE = 3'd3,
    SPACE = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Trigger synchroniser plus edge-history flop
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   trig_prev_reg;
  logic                   trig_sync;
  logic                   edge_rise;
  logic                   edge_fall;
  logic                   edge_qual;

  // Shadow configuration, captured only when an arm is accepted
  logic [DELAY_W-1:0]   delay_sh_reg,   delay_sh_next;
  logic [WIDTH_W-1:0]   width_sh_reg,   width_sh_next;
  logic [COUNT_W-1:0]   num_sh_reg,     num_sh_next;
  logic [SPACING_W-1:0] spacing_sh_reg, spacing_sh_next;
  logic                 falling_sh_reg, falling_sh_next;
  logic                 rearm_sh_reg,   rearm_sh_next;

  // Phase counters
  logic [DELAY_W-1:0]   delay_cnt_reg, delay_cnt_next;
  logic [WIDTH_W-1:0]   width_cnt_reg, width_cnt_next;
  logic [SPACING_W-1:0] space_cnt_reg, space_cnt_next;
  logic [COUNT_W-1:0]   rem_cnt_reg,   rem_cnt_next;

  logic pulse_next, armed_next, busy_next, done_next;

  // Zero width/spacing is stretched to one cycle so pulses never merge
  logic [WIDTH_W-1:0]   width_eff;
  logic [SPACING_W-1:0] spacing_eff;

  assign width_eff   = (width_sh_reg == '0)   ? WIDTH_W'(1)   : width_sh_reg;
  assign spacing_eff = (spacing_sh_reg == '0) ? SPACING_W'(1) : spacing_sh_reg;

  assign trig_sync = sync_reg[SYNC_STAGES-1];
  assign edge_rise = trig_sync & ~trig_prev_reg;
  assign edge_fall = ~trig_sync & trig_prev_reg;
  assign edge_qual = falling_sh_reg ? edge_fall : edge_rise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg       <= '0;
      trig_prev_reg  <= 1'b0;
      state_reg      <= IDLE;
      delay_sh_reg   <= '0;
      width_sh_reg   <= '0;
      num_sh_reg     <= '0;
      spacing_sh_reg <= '0;
      falling_sh_reg <= 1'b0;
      rearm_sh_reg   <= 1'b0;
      delay_cnt_reg  <= '0;
      width_cnt_reg  <= '0;
      space_cnt_reg  <= '0;
      rem_cnt_reg    <= '0;
      pulse_o        <= 1'b0;
      armed_o        <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[SYNC_STAGES-2:0], trigger_i};
      trig_prev_reg  <= trig_sync;
      state_reg      <= state_next;
      delay_sh_reg   <= delay_sh_next;
      width_sh_reg   <= width_sh_next;
      num_sh_reg     <= num_sh_next;
      spacing_sh_reg <= spacing_sh_next;
      falling_sh_reg <= falling_sh_next;
      rearm_sh_reg   <= rearm_sh_next;
      delay_cnt_reg  <= delay_cnt_next;
      width_cnt_reg  <= width_cnt_next;
      space_cnt_reg  <= space_cnt_next;
      rem_cnt_reg    <= rem_cnt_next;
      pulse_o        <= pulse_next;
      armed_o        <= armed_next;
      busy_o         <= busy_next;
      done_o         <= done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    delay_sh_next   = delay_sh_reg;
    width_sh_next   = width_sh_reg;
    num_sh_next     = num_sh_reg;
    spacing_sh_next = spacing_sh_reg;
    falling_sh_next = falling_sh_reg;
    rearm_sh_next   = rearm_sh_reg;
    delay_cnt_next  = delay_cnt_reg;
    width_cnt_next  = width_cnt_reg;
    space_cnt_next  = space_cnt_reg;
    rem_cnt_next    = rem_cnt_reg;
    done_next       = 1'b0;

    if (abort_i && state_reg != IDLE) begin
      // Abort wins over everything; the shadow configuration is kept
      state_next     = IDLE;
      delay_cnt_next = '0;
      width_cnt_next = '0;
      space_cnt_next = '0;
      rem_cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arm_i && !abort_i && num_pulses_i != '0) begin
            state_next      = ARMED;
            delay_sh_next   = delay_i;
            width_sh_next   = width_i;
            num_sh_next     = num_pulses_i;
            spacing_sh_next = spacing_i;
            falling_sh_next = trig_falling_i;
            rearm_sh_next   = auto_rearm_i;
          end
        end
        ARMED: begin
          if (edge_qual) begin
            rem_cnt_next = num_sh_reg;
            if (delay_sh_reg == '0) begin
              state_next     = PULSE;
              width_cnt_next = width_eff;
            end else begin
              state_next     = DELAY;
              delay_cnt_next = delay_sh_reg;
            end
          end
        end
        DELAY: begin
          // Loaded with the delay on entry; the last count leaves on the
          // following edge, so DELAY lasts exactly 'delay' cycles.
          if (delay_cnt_reg <= DELAY_W'(1)) begin
            state_next     = PULSE;
            delay_cnt_next = '0;
            width_cnt_next = width_eff;
          end else begin
            delay_cnt_next = delay_cnt_reg - DELAY_W'(1);
          end
        end
        PULSE: begin
          if (width_cnt_reg <= WIDTH_W'(1)) begin
            width_cnt_next = '0;
            rem_cnt_next   = rem_cnt_reg - COUNT_W'(1);
            if (rem_cnt_reg <= COUNT_W'(1)) begin
              done_next  = 1'b1;
              state_next = rearm_sh_reg ? ARMED : IDLE;
            end else begin
              state_next     = SPACE;
              space_cnt_next = spacing_eff;
            end
          end else begin
            width_cnt_next = width_cnt_reg - WIDTH_W'(1);
          end
        end
        SPACE: begin
          if (space_cnt_reg <= SPACING_W'(1)) begin
            state_next     = PULSE;
            space_cnt_next = '0;
            width_cnt_next = width_eff;
          end else begin
            space_cnt_next = space_cnt_reg - SPACING_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    // Outputs are registered copies of the decoded next state
    pulse_next = (state_next == PULSE);
    armed_next = (state_next == ARMED);
    busy_next  = (state_next == DELAY) || (state_next == PULSE) ||
                 (state_next == SPACE);
  end

endmodule
